dmem_responder: RTL
===================

# dmem_responder

Responder side of the CPU data-memory port: accepts one load/store request at a time from the multicycle CPU and answers after a configurable latency. Stores use byte, half, word or double size; loads are sign- or zero-extended to 64 bits. The block owns its doubleword-organised storage array. It replaces the zero-latency data memory behind the CPU's ALU-output address register, so the control unit can stall on a real handshake.

## Interface

Parameters:
- DEPTH, 256: number of 64-bit doublewords in storage; power of two, 2..65536.
- LATENCY, 2: wait cycles between acceptance and response; 0..15.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 double.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata  in  64  store data, right-aligned (bits [8·2^size−1:0] used).
- resp_valid  out  1  response present.
- resp_ready  in  1  CPU accepts the response.
- resp_rdata  out  64  extended load data; 0 for stores and errors.
- resp_err  out  1  access error (see Configuration).

## Operation

- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, capture write, addr, size, unsigned and wdata.
  - LATENCY=0: go to RESP.
  - Otherwise: load the counter with LATENCY−1 and go to WAIT.
- WAIT: the counter decrements each cycle. At 0, go to RESP. Request inputs are ignored.
- RESP entry edge (the transition into RESP):
  - Load: read the doubleword at index addr[3+:log2(DEPTH)]. Select the lane at byte offset addr[2:0]. Extend it to 64 bits per size and unsigned, and register it into resp_rdata.
  - Store: update only the byte lanes covered by size at offset addr[2:0]. Other bytes are unchanged.
  - Note: size=11 covers all 8 lanes.
- Address wrap: high address bits above the index are ignored, so the index wraps modulo DEPTH.
- RESP: resp_valid=1, with resp_rdata and resp_err held stable. When resp_ready=1, go to IDLE. The next request can be accepted on the following cycle (no bypass).
- Store data is written exactly once per accepted store, even if resp_ready is held low for many cycles.
- Reset asserted at any time:
  - State returns to IDLE and the counter clears.
  - An in-flight store that has not yet reached its RESP entry edge is dropped.
  - Storage contents are not cleared, so the array stays RAM-inferable.

## Timing

- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Latency: acceptance edge to first resp_valid=1 cycle is LATENCY+1 cycles.
  - LATENCY=0: resp_valid is high in the cycle after acceptance.
- Throughput: at most one request per LATENCY+2 cycles with resp_ready tied high.
- req_ready and resp_valid are never high in the same cycle.
- All outputs are registered. There is no combinational path from req_* or resp_ready to any output.
- Load data reflects storage as of the RESP entry edge.

## Configuration

- DMEM_MISALIGN_TRAP_EN defined:
  - A request whose addr[2:0] is not a multiple of 2^size is misaligned. It sets resp_err=1 in RESP with resp_rdata=0.
  - A misaligned store writes nothing.
  - Latency is unchanged.
- Not defined:
  - resp_err is tied 0.
  - Misaligned accesses are silently aligned down by clearing addr[size−1:0] before lane selection, then performed normally.

## Test plan

- Reset and store/load: with reset held low, check req_ready=1, resp_valid=0. Release reset. Store size 11, addr 0x10, data 0x1122334455667788. Then load size 11 at addr 0x10. Expect resp_rdata=0x1122334455667788, with resp_valid rising 3 cycles after acceptance (LATENCY=2).
- Lane merge and extension: after the double above, store byte 0xAB at addr 0x13.
  - Double load at 0x10 returns 0x11223344AB667788.
  - Signed byte load at 0x13 returns 0xFFFFFFFFFFFFFFAB.
  - Unsigned half load at 0x12 returns 0x000000000000AB66.
- Response backpressure: hold resp_ready=0 for 5 cycles after resp_valid rises. resp_valid and resp_rdata stay stable, req_ready stays 0, and the store is written once. The next request is accepted one cycle after resp_ready is sampled high.
- Wrap-around (DEPTH=256): store double 0xCAFE at addr 0x800. A double load at addr 0x0 returns 0xCAFE.
- Misaligned access: word store at addr 0x2 with data 0xDEADBEEF.
  - With DMEM_MISALIGN_TRAP_EN: resp_err=1 and a load of addr 0x0 is unchanged.
  - Without it: resp_err=0 and a word load at 0x0 returns 0xFFFFFFFFDEADBEEF.
- Reset mid-operation: accept a store at 0x20. Pull reset low during WAIT for 1 cycle. No response is produced, storage at 0x20 is unchanged, and the next request is accepted normally.

Source files
------------

// File: rtl/dmem_responder.sv
// CPU data-memory responder: one load/store in flight, fixed response latency,
// byte-lane stores and sign/zero-extended loads. Optional DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   // state | meaning
   // IDLE  | req_ready high, waiting for a request
   // WAIT  | latency counter running, request inputs ignored
   // RESP  | resp_valid high, holding data until resp_ready
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam int         AW       = $clog2(DEPTH);
   localparam bit         LAT_ZERO = (LATENCY == 0);
   localparam logic [3:0] LAT_M1   = LAT_ZERO ? 4'd0 : 4'(LATENCY - 1);

   state_t          state;
   logic [3:0]      cnt;
   logic            cap_write;
   logic            cap_unsigned;
   logic [AW+2:0]   cap_addr;
   logic [1:0]      cap_size;
   logic [63:0]     cap_wdata;

   logic [63:0]     mem [DEPTH];

   logic            eff_write;
   logic            eff_unsigned;
   logic [AW+2:0]   eff_addr;
   logic [1:0]      eff_size;
   logic [63:0]     eff_wdata;
   logic            enter_resp;
   logic [2:0]      low_mask;
   logic [7:0]      byte_mask;
   logic [2:0]      off;
   logic            misalign;
   logic            err_next;
   logic [AW-1:0]   idx;
   logic [7:0]      be;
   logic [63:0]     wdata_sh;
   logic            we;
   logic [63:0]     rd_word;
   logic [63:0]     load_ext;
   logic [63:0]     rdata_next;
   logic            unused_addr_hi;

   assign unused_addr_hi = ^req_addr[63:AW+3];

   // The entry edge uses live request inputs when LATENCY=0, captured ones otherwise.
   always_comb begin
      eff_write    = cap_write;
      eff_unsigned = cap_unsigned;
      eff_addr     = cap_addr;
      eff_size     = cap_size;
      eff_wdata    = cap_wdata;
      if (state == IDLE) begin
         eff_write    = req_write;
         eff_unsigned = req_unsigned;
         eff_addr     = req_addr[AW+2:0];
         eff_size     = req_size;
         eff_wdata    = req_wdata;
      end
      enter_resp = (LAT_ZERO && state == IDLE && req_valid) ||
                   (state == WAIT && cnt == 4'd0);
   end

   always_comb begin
      low_mask  = 3'b000;
      byte_mask = 8'h01;
      case (eff_size)
         2'b00: begin low_mask = 3'b000; byte_mask = 8'h01; end
         2'b01: begin low_mask = 3'b001; byte_mask = 8'h03; end
         2'b10: begin low_mask = 3'b011; byte_mask = 8'h0f; end
         2'b11: begin low_mask = 3'b111; byte_mask = 8'hff; end
         default: ;
      endcase
      misalign = |(eff_addr[2:0] & low_mask);
`ifdef DMEM_MISALIGN_TRAP_EN
      off      = eff_addr[2:0];
      err_next = misalign;
`else
      off      = eff_addr[2:0] & ~low_mask;
      err_next = 1'b0;
`endif
      idx      = eff_addr[AW+2:3];
      be       = byte_mask << off;
      wdata_sh = eff_wdata << {off, 3'b000};
      we       = enter_resp && eff_write && !err_next;
      rd_word  = mem[idx] >> {off, 3'b000};
      load_ext = 64'd0;
      case (eff_size)
         2'b00: load_ext = eff_unsigned ? {56'd0, rd_word[7:0]}
                                        : {{56{rd_word[7]}}, rd_word[7:0]};
         2'b01: load_ext = eff_unsigned ? {48'd0, rd_word[15:0]}
                                        : {{48{rd_word[15]}}, rd_word[15:0]};
         2'b10: load_ext = eff_unsigned ? {32'd0, rd_word[31:0]}
                                        : {{32{rd_word[31]}}, rd_word[31:0]};
         2'b11: load_ext = rd_word;
         default: ;
      endcase
      rdata_next = (eff_write || err_next) ? 64'd0 : load_ext;
   end

   // No reset on the array so it maps onto RAM; the write strobe is gated by state.
   always_ff @(posedge clock) begin
      for (int i = 0; i < 8; i++) begin
         if (we && be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         cap_write    <= 1'b0;
         cap_unsigned <= 1'b0;
         cap_addr     <= '0;
         cap_size     <= 2'b00;
         cap_wdata    <= 64'd0;
         req_ready    <= 1'b1;
         resp_valid   <= 1'b0;
         resp_rdata   <= 64'd0;
         resp_err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cap_write    <= req_write;
                  cap_unsigned <= req_unsigned;
                  cap_addr     <= req_addr[AW+2:0];
                  cap_size     <= req_size;
                  cap_wdata    <= req_wdata;
                  req_ready    <= 1'b0;
                  if (LAT_ZERO) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= rdata_next;
                     resp_err   <= err_next;
                  end else begin
                     state <= WAIT;
                     cnt   <= LAT_M1;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= rdata_next;
                  resp_err   <= err_next;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  req_ready  <= 1'b1;
                  resp_valid <= 1'b0;
                  resp_rdata <= 64'd0;
                  resp_err   <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
